// File: rtl/rvfi_reg_window_check.sv
// RVFI register-file consistency checker: out-of-order retirements are buffered in an
// order-indexed window and committed in rvfi_order sequence against a shadow register file.
module rvfi_reg_window_check #(
    parameter int XLEN  = 32,
    parameter int NRET  = 1,
    parameter int NREGS = 32,
    parameter int DEPTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 check_en,
    input  logic [NRET-1:0]      rvfi_valid,
    input  logic [64*NRET-1:0]   rvfi_order,
    input  logic [5*NRET-1:0]    rvfi_rs1_addr,
    input  logic [5*NRET-1:0]    rvfi_rs2_addr,
    input  logic [XLEN*NRET-1:0] rvfi_rs1_rdata,
    input  logic [XLEN*NRET-1:0] rvfi_rs2_rdata,
    input  logic [5*NRET-1:0]    rvfi_rd_addr,
    input  logic [XLEN*NRET-1:0] rvfi_rd_wdata,
    output logic [63:0]          next_order,
    output logic [7:0]           commit_count,
    output logic                 err_rs,
    output logic                 err_x0,
    output logic                 err_dup,
    output logic                 err_ovf,
    output logic                 err_addr,
    output logic                 err_any,
    output logic [63:0]          err_order
);
    localparam int          AW      = $clog2(DEPTH);
    localparam int          RW      = $clog2(NREGS);
    localparam logic [63:0] DEPTH_W = 64'(DEPTH);
    localparam logic [5:0]  NREGS_W = 6'(NREGS);

    typedef struct packed {
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rs1_rdata;
        logic [XLEN-1:0] rs2_rdata;
        logic [XLEN-1:0] rd_wdata;
    } entry_t;

    entry_t           slot_q   [DEPTH];
    logic [DEPTH-1:0] slot_vld_q;
    logic [XLEN-1:0]  shadow_q [NREGS];
    logic [NREGS-1:0] written_q;

    function automatic logic addr_bad(input logic [4:0] a);
        return {1'b0, a} >= NREGS_W;
    endfunction

    // Insert side. rvfi_valid is a pure strobe: there is no backpressure, every
    // valid channel is either accepted into the window or flagged and dropped.
    logic [NRET-1:0]  ins_acc;
    logic [DEPTH-1:0] ins_set;
    logic [AW-1:0]    ins_slot [NRET];
    entry_t           ins_ent  [NRET];
    logic             ins_dup, ins_ovf, ins_addr, ins_any;
    logic [63:0]      ins_min, c_ord, c_dist;
    logic             c_lower;

    always_comb begin
        ins_acc  = '0;
        ins_set  = '0;
        ins_dup  = 1'b0;
        ins_ovf  = 1'b0;
        ins_addr = 1'b0;
        ins_any  = 1'b0;
        ins_min  = '1;
        c_ord    = '0;
        c_dist   = '0;
        c_lower  = 1'b0;
        for (int c = 0; c < NRET; c++) begin
            c_ord                = rvfi_order[c*64 +: 64];
            c_dist               = c_ord - next_order;
            ins_slot[c]          = c_ord[AW-1:0];
            ins_ent[c].rs1_addr  = rvfi_rs1_addr[c*5 +: 5];
            ins_ent[c].rs2_addr  = rvfi_rs2_addr[c*5 +: 5];
            ins_ent[c].rd_addr   = rvfi_rd_addr[c*5 +: 5];
            ins_ent[c].rs1_rdata = rvfi_rs1_rdata[c*XLEN +: XLEN];
            ins_ent[c].rs2_rdata = rvfi_rs2_rdata[c*XLEN +: XLEN];
            ins_ent[c].rd_wdata  = rvfi_rd_wdata[c*XLEN +: XLEN];
            c_lower = 1'b0;
            for (int j = 0; j < NRET; j++) begin
                if (j < c && rvfi_valid[j] && rvfi_order[j*64 +: 64] == c_ord) c_lower = 1'b1;
            end
            if (rvfi_valid[c]) begin
                if (addr_bad(ins_ent[c].rs1_addr) || addr_bad(ins_ent[c].rs2_addr) ||
                    addr_bad(ins_ent[c].rd_addr)) begin
                    ins_addr = 1'b1;
                    ins_any  = 1'b1;
                    if (c_ord < ins_min) ins_min = c_ord;
                end
                // Judged against the pre-edge window, so a slot freed this cycle is out of range.
                if (c_ord < next_order ||
                    (c_dist < DEPTH_W && (slot_vld_q[ins_slot[c]] || c_lower))) begin
                    ins_dup = 1'b1;
                    ins_any = 1'b1;
                    if (c_ord < ins_min) ins_min = c_ord;
                end else if (c_dist >= DEPTH_W) begin
                    ins_ovf = 1'b1;
                    ins_any = 1'b1;
                    if (c_ord < ins_min) ins_min = c_ord;
                end else begin
                    ins_acc[c]          = 1'b1;
                    ins_set[ins_slot[c]] = 1'b1;
                end
            end
        end
    end

    // Commit side: each commit sees the shadow as updated by earlier commits this cycle.
    logic [7:0]       cm_n;
    logic [DEPTH-1:0] cm_clear;
    logic             cm_rs, cm_x0, cm_any, cm_run, cm_bad;
    logic [63:0]      cm_min, cm_ord;
    logic [AW-1:0]    cm_idx;
    entry_t           cm_ent;
    logic [4:0]       rs_a;
    logic [XLEN-1:0]  rs_d;
    logic [XLEN-1:0]  shadow_n [NREGS];
    logic [NREGS-1:0] written_n;

    always_comb begin
        shadow_n  = shadow_q;
        written_n = written_q;
        cm_n      = '0;
        cm_clear  = '0;
        cm_rs     = 1'b0;
        cm_x0     = 1'b0;
        cm_any    = 1'b0;
        cm_run    = 1'b1;
        cm_bad    = 1'b0;
        cm_min    = '1;
        cm_ord    = '0;
        cm_idx    = '0;
        cm_ent    = '0;
        rs_a      = '0;
        rs_d      = '0;
        for (int i = 0; i < NRET; i++) begin
            cm_ord = next_order + 64'(i);
            cm_idx = cm_ord[AW-1:0];
            cm_run = cm_run & slot_vld_q[cm_idx];
            cm_ent = slot_q[cm_idx];
            cm_bad = 1'b0;
            if (cm_run) begin
                cm_clear[cm_idx] = 1'b1;
                cm_n = cm_n + 8'd1;
                for (int k = 0; k < 2; k++) begin
                    rs_a = (k == 0) ? cm_ent.rs1_addr : cm_ent.rs2_addr;
                    rs_d = (k == 0) ? cm_ent.rs1_rdata : cm_ent.rs2_rdata;
                    if (check_en) begin
                        if (rs_a == 5'd0) begin
                            if (rs_d != '0) begin
                                cm_x0  = 1'b1;
                                cm_bad = 1'b1;
                            end
                        end else if (!addr_bad(rs_a) && written_n[rs_a[RW-1:0]] &&
                                     rs_d != shadow_n[rs_a[RW-1:0]]) begin
                            cm_rs  = 1'b1;
                            cm_bad = 1'b1;
                        end
                    end
                end
                if (cm_ent.rd_addr == 5'd0) begin
                    if (check_en && cm_ent.rd_wdata != '0) begin
                        cm_x0  = 1'b1;
                        cm_bad = 1'b1;
                    end
                end else if (!addr_bad(cm_ent.rd_addr)) begin
                    shadow_n[cm_ent.rd_addr[RW-1:0]]  = cm_ent.rd_wdata;
                    written_n[cm_ent.rd_addr[RW-1:0]] = 1'b1;
                end
                if (cm_bad) begin
                    cm_any = 1'b1;
                    if (cm_ord < cm_min) cm_min = cm_ord;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            next_order   <= '0;
            commit_count <= '0;
            err_rs       <= 1'b0;
            err_x0       <= 1'b0;
            err_dup      <= 1'b0;
            err_ovf      <= 1'b0;
            err_addr     <= 1'b0;
            err_any      <= 1'b0;
            err_order    <= '0;
            slot_vld_q   <= '0;
            written_q    <= '0;
            for (int d = 0; d < DEPTH; d++) slot_q[d] <= '0;
            for (int r = 0; r < NREGS; r++) shadow_q[r] <= '0;
        end else begin
            next_order   <= next_order + 64'(cm_n);
            commit_count <= cm_n;
            slot_vld_q   <= (slot_vld_q & ~cm_clear) | ins_set;
            for (int c = 0; c < NRET; c++) begin
                if (ins_acc[c]) slot_q[ins_slot[c]] <= ins_ent[c];
            end
            shadow_q  <= shadow_n;
            written_q <= written_n;
            err_rs    <= err_rs | cm_rs;
            err_x0    <= err_x0 | cm_x0;
            err_dup   <= err_dup | ins_dup;
            err_ovf   <= err_ovf | ins_ovf;
            err_addr  <= err_addr | ins_addr;
            err_any   <= err_any | ins_any | cm_any;
            if (!err_any && (ins_any || cm_any)) begin
                err_order <= (ins_min < cm_min) ? ins_min : cm_min;
            end
        end
    end

endmodule
